// File: rtl/hazard_controller.sv
// Hazard controller for the five-stage pipeline: operand forwarding,
// load-use / branch / HI-LO stalls and multi-cycle MDU occupancy tracking.
module hazard_controller #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs_d_i,
  input  logic [4:0] rt_d_i,
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rt_e_i,
  input  logic [4:0] write_reg_e_i,
  input  logic [4:0] write_reg_m_i,
  input  logic [4:0] write_reg_w_i,
  input  logic       reg_write_e_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  input  logic       mem_to_reg_e_i,
  input  logic       mem_to_reg_m_i,
  input  logic       branch_d_i,
  input  logic       jump_reg_d_i,
  input  logic       hilo_access_d_i,
  input  logic       mdu_start_e_i,
  input  logic       mdu_div_e_i,
  output logic       forward_a_d_o,
  output logic       forward_b_d_o,
  output logic [1:0] forward_a_e_o,
  output logic [1:0] forward_b_e_o,
  output logic       stall_f_o,
  output logic       stall_d_o,
  output logic       flush_e_o,
  output logic       mdu_busy_o
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic lw_stall;
  logic br_stall;
  logic mdu_stall;
  logic stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  // Execute-stage operand bypass: memory stage wins over writeback.
  always_comb begin
    forward_a_e_o = 2'b00;
    forward_b_e_o = 2'b00;
    if (reg_write_m_i && reg_match(write_reg_m_i, rs_e_i))
      forward_a_e_o = 2'b10;
    else if (reg_write_w_i && reg_match(write_reg_w_i, rs_e_i))
      forward_a_e_o = 2'b01;
    if (reg_write_m_i && reg_match(write_reg_m_i, rt_e_i))
      forward_b_e_o = 2'b10;
    else if (reg_write_w_i && reg_match(write_reg_w_i, rt_e_i))
      forward_b_e_o = 2'b01;
  end

  // Decode-stage bypass of the memory-stage ALU result for branch compares.
  always_comb begin
    forward_a_d_o = reg_write_m_i && reg_match(write_reg_m_i, rs_d_i);
    forward_b_d_o = reg_write_m_i && reg_match(write_reg_m_i, rt_d_i);
  end

  // Stall sources; jr/jalr only read rs, branches read rs and rt.
  always_comb begin
    lw_stall = mem_to_reg_e_i &&
               (reg_match(write_reg_e_i, rs_d_i) || reg_match(write_reg_e_i, rt_d_i));
    br_stall = 1'b0;
    if (branch_d_i) begin
      br_stall = (reg_write_e_i &&
                  (reg_match(write_reg_e_i, rs_d_i) || reg_match(write_reg_e_i, rt_d_i))) ||
                 (mem_to_reg_m_i &&
                  (reg_match(write_reg_m_i, rs_d_i) || reg_match(write_reg_m_i, rt_d_i)));
    end
    if (jump_reg_d_i) begin
      br_stall = br_stall ||
                 (reg_write_e_i && reg_match(write_reg_e_i, rs_d_i)) ||
                 (mem_to_reg_m_i && reg_match(write_reg_m_i, rs_d_i));
    end
    mdu_stall = hilo_access_d_i && ((state == BUSY) || mdu_start_e_i);
    stall     = lw_stall || br_stall || mdu_stall;
    stall_f_o = stall;
    stall_d_o = stall;
    flush_e_o = stall;
  end

  // MDU occupancy: BUSY for exactly N cycles after the start cycle; starts while BUSY are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      mdu_busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start_e_i) begin
            cnt        <= mdu_div_e_i ? DIV_LOAD : MULT_LOAD;
            state      <= BUSY;
            mdu_busy_o <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= IDLE;
            mdu_busy_o <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          mdu_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_controller;

  localparam int unsigned MULT_N = 4;
  localparam int unsigned DIV_N  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w, mtr_e, mtr_m, br_d, jr_d, hilo_d, start_e, div_e;
  logic       fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, busy;
  logic [1:0] fwd_a_e, fwd_b_e;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;
  int model_rem = 0;  // cycles of MDU occupancy still to come after this one

  hazard_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs_d_i(rs_d), .rt_d_i(rt_d), .rs_e_i(rs_e), .rt_e_i(rt_e),
    .write_reg_e_i(wr_e), .write_reg_m_i(wr_m), .write_reg_w_i(wr_w),
    .reg_write_e_i(rw_e), .reg_write_m_i(rw_m), .reg_write_w_i(rw_w),
    .mem_to_reg_e_i(mtr_e), .mem_to_reg_m_i(mtr_m),
    .branch_d_i(br_d), .jump_reg_d_i(jr_d), .hilo_access_d_i(hilo_d),
    .mdu_start_e_i(start_e), .mdu_div_e_i(div_e),
    .forward_a_d_o(fwd_a_d), .forward_b_d_o(fwd_b_d),
    .forward_a_e_o(fwd_a_e), .forward_b_e_o(fwd_b_e),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .flush_e_o(flush_e),
    .mdu_busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (rw_m && dep(wr_m, src)) return 2'b10;
    if (rw_w && dep(wr_w, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Occupancy model: a start seen while idle books N cycles of busy time.
  always @(posedge clk) begin
    if (rst) model_rem <= 0;
    else if (model_rem > 0) model_rem <= model_rem - 1;
    else if (start_e) model_rem <= div_e ? DIV_N : MULT_N;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      automatic bit lw  = mtr_e && (dep(wr_e, rs_d) || dep(wr_e, rt_d));
      automatic bit srcs_e = (rw_e && dep(wr_e, rs_d)) || (rw_e && br_d && dep(wr_e, rt_d));
      automatic bit srcs_m = (mtr_m && dep(wr_m, rs_d)) || (mtr_m && br_d && dep(wr_m, rt_d));
      automatic bit bs  = (br_d || jr_d) && (srcs_e || srcs_m);
      automatic bit ms  = hilo_d && (model_rem > 0 || start_e);
      automatic bit st  = lw || bs || ms;
      chk("model_fwd_a_e", 32'(fwd_a_e), 32'(fwd_e(rs_e)));
      chk("model_fwd_b_e", 32'(fwd_b_e), 32'(fwd_e(rt_e)));
      chk("model_fwd_a_d", 32'(fwd_a_d), 32'(rw_m && dep(wr_m, rs_d)));
      chk("model_fwd_b_d", 32'(fwd_b_d), 32'(rw_m && dep(wr_m, rt_d)));
      chk("model_stall_f", 32'(stall_f), 32'(st));
      chk("model_stall_d", 32'(stall_d), 32'(st));
      chk("model_flush_e", 32'(flush_e), 32'(st));
      chk("model_busy",    32'(busy),    32'(model_rem > 0));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
    {rw_e, rw_m, rw_w, mtr_e, mtr_m, br_d, jr_d, hilo_d, start_e, div_e} = '0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, "_stall_f"}, 32'(stall_f), 32'(exp));
    chk({name, "_stall_d"}, 32'(stall_d), 32'(exp));
    chk({name, "_flush_e"}, 32'(flush_e), 32'(exp));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_fwd"}, 32'({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}), 32'd0);
    chk_stall(name, 1'b0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check_en = 1'b1;
    #1 chk_all_zero("reset");

    // Forwarding priority
    cycle();
    rs_e = 5; wr_m = 5; rw_m = 1; wr_w = 5; rw_w = 1;
    #1 chk("fwd_mem_prio", 32'(fwd_a_e), 32'd2);
    cycle();
    rw_m = 0;
    #1 chk("fwd_wb", 32'(fwd_a_e), 32'd1);
    cycle();
    rw_m = 1; rs_e = 0;
    #1 chk("fwd_r0", 32'(fwd_a_e), 32'd0);

    // Load-use
    cycle();
    idle_inputs();
    mtr_e = 1; wr_e = 8; rt_d = 8;
    #1 chk_stall("loaduse", 1'b1);
    cycle();
    wr_e = 0;
    #1 chk_stall("loaduse_r0", 1'b0);

    // Branch hazard then resolved by decode forwarding
    cycle();
    idle_inputs();
    br_d = 1; rs_d = 3; rw_e = 1; wr_e = 3;
    #1 chk_stall("branch", 1'b1);
    cycle();
    rw_e = 0; wr_e = 0; wr_m = 3; rw_m = 1; mtr_m = 0;
    #1 chk_stall("branch_fwd", 1'b0);
    chk("branch_fwd_a_d", 32'(fwd_a_d), 32'd1);

    // Multiply with a HI/LO access waiting in decode
    cycle();
    idle_inputs();
    cycle();
    hilo_d = 1; start_e = 1; div_e = 0;
    #1 chk_stall("mult_t0", 1'b1);
    chk("mult_t0_busy", 32'(busy), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      start_e = 0;
      #1 chk_stall("mult_busy", 1'b1);
      chk("mult_busy_hi", 32'(busy), 32'd1);
    end
    cycle();
    #1 chk_stall("mult_release", 1'b0);
    chk("mult_done", 32'(busy), 32'd0);

    // Divide with a second start while busy: no reload
    cycle();
    idle_inputs();
    start_e = 1; div_e = 1;
    cycle();
    start_e = 1; div_e = 0;
    #1 chk("div_t1_busy", 32'(busy), 32'd1);
    cycle();
    start_e = 0;
    repeat (30) cycle();
    #1 chk("div_t32_busy", 32'(busy), 32'd1);
    cycle();
    #1 chk("div_t33_idle", 32'(busy), 32'd0);

    // Reset mid-divide
    cycle();
    start_e = 1; div_e = 1;
    cycle();
    idle_inputs();
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk_all_zero("reset_mid_busy");

    // Randomized traffic, small register range for frequent matches
    for (int n = 0; n < 3000; n++) begin
      cycle();
      rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
      rs_e = 5'($urandom_range(0, 7)); rt_e = 5'($urandom_range(0, 7));
      wr_e = 5'($urandom_range(0, 7)); wr_m = 5'($urandom_range(0, 7));
      wr_w = 5'($urandom_range(0, 7));
      rw_e = 1'($urandom); rw_m = 1'($urandom); rw_w = 1'($urandom);
      mtr_e = 1'($urandom); mtr_m = 1'($urandom);
      br_d = ($urandom_range(0, 3) == 0); jr_d = ($urandom_range(0, 3) == 0);
      hilo_d = 1'($urandom);
      start_e = ($urandom_range(0, 7) == 0); div_e = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    cycle();
    rst = 1'b0;
    cycle();
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
